// File: rtl/vga_timing_delay.sv
// vga_timing_delay
//   Runtime-programmable delay line for the VGA timing bus plus an auxiliary
//   payload. It realigns timing with pipelined pixel data. The delay is chosen
//   with del_sel and is clamped to MAX_DEL. The shift register can be stalled
//   with en. Until the line holds enough history for the selected delay, the
//   outputs are forced to idle values.
//
// Ports
//   clk                  pixel clock; all state changes on the rising edge
//   rst                  asynchronous reset, active low
//   en                   shift enable; 0 stalls the history and the fill count
//   del_sel              requested delay in cycles (clamped to MAX_DEL)
//   hcount_in/vcount_in  timing counters (11 bits each)
//   hsync_in/vsync_in    sync strobes
//   hblnk_in/vblnk_in    blanking strobes
//   aux_in               payload delayed together with the timing signals
//   *_out                delayed (or idle) versions of the inputs
//   primed               1 when the outputs carry real delayed input
module vga_timing_delay #(
    parameter int unsigned MAX_DEL   = 8,
    parameter int unsigned AUX_W     = 12,
    parameter logic        SYNC_IDLE = 1'b0,
    localparam int unsigned DW       = $clog2(MAX_DEL + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DW-1:0]    del_sel,
    input  logic [10:0]      hcount_in,
    input  logic [10:0]      vcount_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             hblnk_in,
    input  logic             vblnk_in,
    input  logic [AUX_W-1:0] aux_in,
    output logic [10:0]      hcount_out,
    output logic [10:0]      vcount_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             hblnk_out,
    output logic             vblnk_out,
    output logic [AUX_W-1:0] aux_out,
    output logic             primed
);

    localparam int unsigned BW = 26 + AUX_W;

    logic [BW-1:0] b_in;
    logic [BW-1:0] b_idle;
    logic [BW-1:0] b_sel;
    logic [BW-1:0] b_out;
    logic [BW-1:0] stage [MAX_DEL];
    logic [DW-1:0] fc;
    logic [DW-1:0] d;

    assign b_in   = {hcount_in, vcount_in, hsync_in, vsync_in,
                     hblnk_in, vblnk_in, aux_in};
    assign b_idle = {11'd0, 11'd0, SYNC_IDLE, SYNC_IDLE, 1'b1, 1'b1,
                     AUX_W'(0)};

    // Effective delay: del_sel clamped to MAX_DEL.
    always_comb begin
        d = del_sel;
        if (del_sel > DW'(MAX_DEL))
            d = DW'(MAX_DEL);
    end

    // stage[k] holds the input accepted k+1 enabled edges ago.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < MAX_DEL; k++)
                stage[k] <= b_idle;
            fc <= '0;
        end else if (en) begin
            stage[0] <= b_in;
            for (int unsigned k = 1; k < MAX_DEL; k++)
                stage[k] <= stage[k-1];
            if (fc != DW'(MAX_DEL))
                fc <= fc + 1'b1;
        end
    end

    // The tap is selected by comparison. This avoids an out-of-range index
    // when d = 0 (bypass).
    always_comb begin
        b_sel = b_in;
        for (int unsigned k = 0; k < MAX_DEL; k++)
            if (d == DW'(k + 1))
                b_sel = stage[k];
    end

    assign primed = (d == '0) || (fc >= d);
    assign b_out  = primed ? b_sel : b_idle;

    assign {hcount_out, vcount_out, hsync_out, vsync_out,
            hblnk_out, vblnk_out, aux_out} = b_out;

endmodule

// File: tb/tb_vga_timing_delay.sv
module tb_vga_timing_delay;

    localparam int unsigned MAX_DEL = 8;
    localparam int unsigned AUX_W   = 12;
    localparam logic        SYNC_I  = 1'b0;
    localparam int unsigned BW      = 26 + AUX_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [3:0]    del_sel;
    logic [BW-1:0] in_b;
    logic [BW-1:0] out_b;

    logic [10:0] hcount_in, vcount_in, hcount_out, vcount_out;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out, primed;
    logic [AUX_W-1:0] aux_in, aux_out;

    assign {hcount_in, vcount_in, hsync_in, vsync_in,
            hblnk_in, vblnk_in, aux_in} = in_b;
    assign out_b = {hcount_out, vcount_out, hsync_out, vsync_out,
                    hblnk_out, vblnk_out, aux_out};

    vga_timing_delay #(
        .MAX_DEL  (MAX_DEL),
        .AUX_W    (AUX_W),
        .SYNC_IDLE(SYNC_I)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .del_sel   (del_sel),
        .hcount_in (hcount_in),
        .vcount_in (vcount_in),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .hblnk_in  (hblnk_in),
        .vblnk_in  (vblnk_in),
        .aux_in    (aux_in),
        .hcount_out(hcount_out),
        .vcount_out(vcount_out),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .hblnk_out (hblnk_out),
        .vblnk_out (vblnk_out),
        .aux_out   (aux_out),
        .primed    (primed)
    );

    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned errors  = 0;
    int unsigned n       = 0;       // ramp counter for stimulus
    int unsigned fc_m    = 0;       // model fill count
    logic [BW-1:0] hist[$];         // accepted inputs, newest first
    logic [BW-1:0] exp_b;
    logic          exp_p;

    localparam logic [BW-1:0] IDLE_B = {11'd0, 11'd0, SYNC_I, SYNC_I,
                                        1'b1, 1'b1, 12'd0};

    function automatic logic [BW-1:0] mk(input int unsigned v);
        logic [31:0] t;
        t = v;
        return {t[10:0], 11'(v * 3 + 5), t[2], t[4], t[1], t[3],
                12'(v * 7 + 1)};
    endfunction

    function automatic void model_expect(output logic [BW-1:0] eb,
                                         output logic ep);
        int unsigned dd;
        dd = (del_sel > 4'(MAX_DEL)) ? MAX_DEL : int'(del_sel);
        if (dd == 0) begin
            eb = in_b; ep = 1'b1;
        end else if (fc_m >= dd) begin
            eb = hist[dd-1]; ep = 1'b1;
        end else begin
            eb = IDLE_B; ep = 1'b0;
        end
    endfunction

    task automatic model_reset();
        fc_m = 0;
        hist.delete();
    endtask

    // One rising edge. The model is updated on accepted edges, and the task
    // returns 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        if (rst && en) begin
            hist.push_front(in_b);
            if (hist.size() > MAX_DEL) void'(hist.pop_back());
            if (fc_m < MAX_DEL) fc_m++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; del_sel = 4'd4; in_b = mk(100);
        model_reset();
        #2;
        vectors++;
        if (out_b !== IDLE_B) begin
            errors++; $display("FAIL reset_idle: got %h want %h", out_b, IDLE_B);
        end
        vectors++;
        if (primed !== 1'b0) begin
            errors++; $display("FAIL reset_primed: got %b want 0", primed);
        end
        // The bypass path works while rst is held low.
        del_sel = 4'd0;
        for (int i = 0; i < 3; i++) begin
            in_b = mk(200 + i * 17);
            #1;
            vectors++;
            if (out_b !== in_b) begin
                errors++; $display("FAIL bypass[%0d]: got %h want %h", i, out_b, in_b);
            end
            vectors++;
            if (primed !== 1'b1) begin
                errors++; $display("FAIL bypass_primed[%0d]: got %b want 1", i, primed);
            end
        end
        del_sel = 4'd4;
    endtask

    task automatic test_fill();
        @(negedge clk);
        rst = 1'b1; n = 0;
        for (int e = 1; e <= 12; e++) begin
            in_b = mk(n); n++;
            step();
            model_expect(exp_b, exp_p);
            vectors++;
            if (out_b !== exp_b) begin
                errors++; $display("FAIL fill[%0d]: got %h want %h", e, out_b, exp_b);
            end
            vectors++;
            if (primed !== exp_p) begin
                errors++; $display("FAIL fill_primed[%0d]: got %b want %b", e, primed, exp_p);
            end
            if (e <= 3) begin
                vectors++;
                if (hblnk_out !== 1'b1 || hsync_out !== SYNC_I || primed !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_idle[%0d]: got hblnk=%b hsync=%b primed=%b want 1 %b 0",
                             e, hblnk_out, hsync_out, primed, SYNC_I);
                end
            end else begin
                vectors++;
                if (hcount_out !== 11'(e - 4) || primed !== 1'b1) begin
                    errors++;
                    $display("FAIL fill_ramp[%0d]: got hcount=%0d primed=%b want %0d 1",
                             e, hcount_out, primed, e - 4);
                end
            end
        end
    endtask

    task automatic test_switch();
        del_sel = 4'd2;
        for (int i = 0; i < 20; i++) begin
            in_b = mk(n); n++;
            step();
            model_expect(exp_b, exp_p);
            vectors++;
            if (out_b !== exp_b || primed !== exp_p) begin
                errors++;
                $display("FAIL switch_d2[%0d]: got %h/%b want %h/%b", i, out_b, primed, exp_b, exp_p);
            end
        end
        // The last accepted value is n-1, so d=2 shows n-2 and d=6 shows n-6.
        del_sel = 4'd6;
        #1;
        vectors++;
        if (hcount_out !== 11'(n - 6) || primed !== 1'b1) begin
            errors++;
            $display("FAIL switch_jump: got hcount=%0d primed=%b want %0d 1", hcount_out, primed, n - 6);
        end
        // After reset, fill to fc=3 at d=2, then request d=6.
        rst = 1'b0; model_reset(); del_sel = 4'd2;
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_b = mk(n); n++;
            step();
        end
        vectors++;
        if (primed !== 1'b1) begin
            errors++; $display("FAIL switch_fc3_d2: got primed=%b want 1", primed);
        end
        del_sel = 4'd6;
        #1;
        vectors++;
        if (primed !== 1'b0 || out_b !== IDLE_B) begin
            errors++; $display("FAIL switch_fc3_d6: got %h/%b want %h/0", out_b, primed, IDLE_B);
        end
        for (int i = 4; i <= 8; i++) begin
            in_b = mk(n); n++;
            step();
            model_expect(exp_b, exp_p);
            vectors++;
            if (out_b !== exp_b || primed !== exp_p) begin
                errors++;
                $display("FAIL switch_refill[fc%0d]: got %h/%b want %h/%b", i, out_b, primed, exp_b, exp_p);
            end
        end
    endtask

    task automatic test_stall();
        del_sel = 4'd3;
        for (int i = 0; i < 4; i++) begin
            in_b = mk(n); n++;
            step();
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_b = mk(3000 + i * 11);     // must not be captured
            step();
            model_expect(exp_b, exp_p);
            vectors++;
            if (out_b !== exp_b || primed !== exp_p) begin
                errors++;
                $display("FAIL stall[%0d]: got %h/%b want %h/%b", i, out_b, primed, exp_b, exp_p);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_b = mk(n); n++;
            step();
            model_expect(exp_b, exp_p);
            vectors++;
            if (out_b !== exp_b || hcount_out !== 11'(n - 3)) begin
                errors++;
                $display("FAIL stall_resume[%0d]: got %h want %h (hcount %0d)", i, out_b, exp_b, n - 3);
            end
        end
    endtask

    task automatic test_clamp_reset();
        del_sel = 4'd15;
        for (int i = 0; i < 10; i++) begin
            in_b = mk(n); n++;
            step();
            model_expect(exp_b, exp_p);
            vectors++;
            if (out_b !== exp_b || hcount_out !== 11'(n - 8)) begin
                errors++;
                $display("FAIL clamp[%0d]: got %h want %h (hcount %0d)", i, out_b, exp_b, n - 8);
            end
        end
        // Reset pulse lasting half a clock period, away from the rising edge.
        rst = 1'b0; model_reset();
        #1;
        vectors++;
        if (out_b !== IDLE_B || primed !== 1'b0) begin
            errors++; $display("FAIL midreset_idle: got %h/%b want %h/0", out_b, primed, IDLE_B);
        end
        #4 rst = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            in_b = mk(n); n++;
            step();
            model_expect(exp_b, exp_p);
            vectors++;
            if (out_b !== exp_b || primed !== exp_p || primed !== (e >= 8)) begin
                errors++;
                $display("FAIL refill[%0d]: got %h/%b want %h/%b", e, out_b, primed, exp_b, exp_p);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_switch();
        test_stall();
        test_clamp_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
